// File: rtl/uart_rx_oversampled_if.sv
// Receive-side serial interface: line input, rate select and the received-byte outputs.
interface uart_rx_oversampled_if;
   logic       RxD;
   logic [1:0] BaudSelect;
   logic [7:0] rx_data;
   logic       rx_data_ready;
   logic       rx_frame_err;
   logic       rx_busy;

   // Receiver side: samples the line, produces bytes and status strobes.
   modport master (
      input  RxD,
      input  BaudSelect,
      output rx_data,
      output rx_data_ready,
      output rx_frame_err,
      output rx_busy
   );

   // Line driver / byte consumer side.
   modport slave (
      output RxD,
      output BaudSelect,
      input  rx_data,
      input  rx_data_ready,
      input  rx_frame_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 16x fractional oversampling, 3-sample majority filter,
// mid-bit sampling, run-time selectable baud rate latched at start detection.
module uart_rx_oversampled #(
   parameter int unsigned CLK_FREQ  = 24_000_000,
   parameter int unsigned BAUD_0    = 1200,
   parameter int unsigned BAUD_1    = 9600,
   parameter int unsigned BAUD_2    = 38400,
   parameter int unsigned BAUD_3    = 115200,
   parameter int unsigned ACC_WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   uart_rx_oversampled_if.master rxIf
);

   // round(baud * 16 * 2^ACC_WIDTH / CLK_FREQ)
   function automatic logic [ACC_WIDTH-1:0] incFor(input longint unsigned baud);
      longint unsigned num;
      num = baud * 64'd32 * (64'd1 << ACC_WIDTH) + 64'(CLK_FREQ);
      return ACC_WIDTH'(num / (64'd2 * 64'(CLK_FREQ)));
   endfunction

   localparam logic [ACC_WIDTH-1:0] INC_0 = incFor(64'(BAUD_0));
   localparam logic [ACC_WIDTH-1:0] INC_1 = incFor(64'(BAUD_1));
   localparam logic [ACC_WIDTH-1:0] INC_2 = incFor(64'(BAUD_2));
   localparam logic [ACC_WIDTH-1:0] INC_3 = incFor(64'(BAUD_3));

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

   logic [1:0]           syncReg;
   logic                 rxSync;
   logic [ACC_WIDTH:0]   acc;
   logic                 tick;
   logic [ACC_WIDTH-1:0] incSel;
   logic [1:0]           rateSel;
   logic [2:0]           filt;
   logic                 rxf;

   stateT      state, stateNext;
   logic [3:0] sampleCnt, sampleCntNext;
   logic [2:0] bitCnt, bitCntNext;
   logic [7:0] shiftReg, shiftNext;
   logic [7:0] dataReg, dataNext;
   logic [1:0] baudLat, baudLatNext;
   logic       readyReg, readyNext;
   logic       errReg, errNext;
   logic       busyReg;

   assign rxSync = syncReg[1];
   assign tick   = acc[ACC_WIDTH];
   assign rxf    = (filt[0] & filt[1]) | (filt[0] & filt[2]) | (filt[1] & filt[2]);

   // Two-flop synchronizer for the asynchronous line (idles high).
   always_ff @(posedge clk) begin
      if (rst) syncReg <= '1;
      else     syncReg <= {syncReg[0], rxIf.RxD};
   end

   // Rate increment: frozen to the latched rate for the whole frame.
   always_comb begin
      rateSel = busyReg ? baudLat : rxIf.BaudSelect;
      incSel  = INC_0;
      case (rateSel)
         2'b00:   incSel = INC_0;
         2'b01:   incSel = INC_1;
         2'b10:   incSel = INC_2;
         default: incSel = INC_3;
      endcase
   end

   // Free-running fractional accumulator; its carry is the oversample tick.
   always_ff @(posedge clk) begin
      if (rst) acc <= '0;
      else     acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, incSel};
   end

   // Majority filter history, shifted once per oversample tick.
   always_ff @(posedge clk) begin
      if (rst)       filt <= '1;
      else if (tick) filt <= {filt[1:0], rxSync};
   end

   // Frame FSM next-state and datapath updates.
   always_comb begin
      stateNext     = state;
      sampleCntNext = sampleCnt;
      bitCntNext    = bitCnt;
      shiftNext     = shiftReg;
      dataNext      = dataReg;
      baudLatNext   = baudLat;
      readyNext     = 1'b0;
      errNext       = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rxf) begin
                  baudLatNext   = rxIf.BaudSelect;
                  sampleCntNext = '0;
                  stateNext     = START;
               end
            end
            START: begin
               sampleCntNext = sampleCnt + 4'd1;
               if (sampleCnt == 4'd6) begin
                  if (!rxf) begin
                     sampleCntNext = '0;
                     bitCntNext    = '0;
                     stateNext     = DATA;
                  end else begin
                     stateNext = IDLE;
                  end
               end
            end
            DATA: begin
               // 4-bit counter wraps, so every 16th tick lands on the next bit centre.
               sampleCntNext = sampleCnt + 4'd1;
               if (sampleCnt == 4'd15) begin
                  shiftNext  = {rxf, shiftReg[7:1]};
                  bitCntNext = bitCnt + 3'd1;
                  if (bitCnt == 3'd7) stateNext = STOP;
               end
            end
            STOP: begin
               sampleCntNext = sampleCnt + 4'd1;
               if (sampleCnt == 4'd15) begin
                  if (rxf) begin
                     dataNext  = shiftReg;
                     readyNext = 1'b1;
                     stateNext = IDLE;
                  end else begin
                     errNext   = 1'b1;
                     stateNext = BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxf) stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sampleCnt <= '0;
         bitCnt    <= '0;
         shiftReg  <= '0;
         dataReg   <= '0;
         baudLat   <= '0;
         readyReg  <= 1'b0;
         errReg    <= 1'b0;
         busyReg   <= 1'b0;
      end else begin
         state     <= stateNext;
         sampleCnt <= sampleCntNext;
         bitCnt    <= bitCntNext;
         shiftReg  <= shiftNext;
         dataReg   <= dataNext;
         baudLat   <= baudLatNext;
         readyReg  <= readyNext;
         errReg    <= errNext;
         busyReg   <= (stateNext != IDLE);
      end
   end

   assign rxIf.rx_data       = dataReg;
   assign rxIf.rx_data_ready = readyReg;
   assign rxIf.rx_frame_err  = errReg;
   assign rxIf.rx_busy       = busyReg;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: vector table, corner-case
// sequences and randomized frames checked against a byte-level reference model.
module tb_uart_rx_oversampled;

   localparam int unsigned CLK_FREQ = 24_000_000;
   // Slowest rate raised so the rate-change frame stays short in simulation.
   localparam int unsigned BAUD_0 = 57600;
   localparam int unsigned BAUD_1 = 9600;
   localparam int unsigned BAUD_2 = 38400;
   localparam int unsigned BAUD_3 = 115200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_oversampled_if bus ();

   uart_rx_oversampled #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_0   (BAUD_0),
      .BAUD_1   (BAUD_1),
      .BAUD_2   (BAUD_2),
      .BAUD_3   (BAUD_3),
      .ACC_WIDTH(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rxIf(bus.master)
   );

   int total = 0;
   int bad   = 0;

   // Observed-event bookkeeping, written only by the monitor.
   int         readyCnt  = 0;
   int         errCnt    = 0;
   int         widthViol = 0;
   int         dataViol  = 0;
   logic [7:0] gotQ[$];
   logic       prevReady = 1'b0;
   logic       prevErr   = 1'b0;
   logic       prevRst   = 1'b1;
   logic [7:0] prevData  = 8'h00;

   // Monitor on the falling edge: counts strobes, records bytes, checks pulse width and data hold.
   always @(negedge clk) begin
      if (bus.rx_data_ready) begin
         readyCnt <= readyCnt + 1;
         gotQ.push_back(bus.rx_data);
      end
      if (bus.rx_frame_err) errCnt <= errCnt + 1;
      if ((bus.rx_data_ready && prevReady) || (bus.rx_frame_err && prevErr))
         widthViol <= widthViol + 1;
      if (!rst && !prevRst && !bus.rx_data_ready && (bus.rx_data !== prevData))
         dataViol <= dataViol + 1;
      prevReady <= bus.rx_data_ready;
      prevErr   <= bus.rx_frame_err;
      prevRst   <= rst;
      prevData  <= bus.rx_data;
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tickWait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic int bitClkFor(input logic [1:0] sel);
      case (sel)
         2'b00:   return int'(CLK_FREQ / BAUD_0);
         2'b01:   return int'(CLK_FREQ / BAUD_1);
         2'b10:   return int'(CLK_FREQ / BAUD_2);
         default: return int'(CLK_FREQ / BAUD_3);
      endcase
   endfunction

   // Start bit, 8 data bits LSB first, stop bit, optional extra low hold, then idle high.
   task automatic sendFrame(input logic [7:0] b, input logic stopV, input int holdBits, input int bc);
      bus.RxD = 1'b0;
      tickWait(bc);
      for (int i = 0; i < 8; i++) begin
         bus.RxD = b[i];
         tickWait(bc);
      end
      bus.RxD = stopV;
      tickWait(bc);
      if (holdBits > 0) begin
         bus.RxD = 1'b0;
         tickWait(holdBits * bc);
      end
      bus.RxD = 1'b1;
   endtask

   typedef struct {
      logic [1:0] sel;
      logic [7:0] dat;
      logic       stopOk;
      int         holdBits;
      int         expReady;
      int         expErr;
      logic [7:0] expData;
   } vecT;

   vecT vecs[5];

   initial begin
      int         r0, e0, q0, bc;
      logic [7:0] lastGood, rb, d0;
      logic [1:0] rs;
      logic       rStop;

      vecs[0] = '{2'b11, 8'h55, 1'b1, 0, 1, 0, 8'h55};
      vecs[1] = '{2'b11, 8'h3C, 1'b0, 3, 0, 1, 8'h55};
      vecs[2] = '{2'b11, 8'h7E, 1'b1, 0, 1, 0, 8'h7E};
      vecs[3] = '{2'b10, 8'h00, 1'b1, 0, 1, 0, 8'h00};
      vecs[4] = '{2'b00, 8'hFF, 1'b1, 0, 1, 0, 8'hFF};

      // Reset state.
      rst            = 1'b1;
      bus.RxD        = 1'b1;
      bus.BaudSelect = 2'b11;
      tickWait(5);
      check("reset rx_data", bus.rx_data, 0);
      check("reset rx_data_ready", bus.rx_data_ready, 0);
      check("reset rx_frame_err", bus.rx_frame_err, 0);
      check("reset rx_busy", bus.rx_busy, 0);
      rst = 1'b0;
      tickWait(50);

      // Vector table.
      for (int v = 0; v < 5; v++) begin
         bus.BaudSelect = vecs[v].sel;
         bc = bitClkFor(vecs[v].sel);
         tickWait(20);
         r0 = readyCnt;
         e0 = errCnt;
         sendFrame(vecs[v].dat, vecs[v].stopOk, vecs[v].holdBits, bc);
         tickWait(bc);
         check($sformatf("vec%0d ready count", v), readyCnt - r0, vecs[v].expReady);
         check($sformatf("vec%0d frame_err count", v), errCnt - e0, vecs[v].expErr);
         check($sformatf("vec%0d rx_data", v), bus.rx_data, vecs[v].expData);
         check($sformatf("vec%0d rx_busy idle", v), bus.rx_busy, 0);
      end
      lastGood = 8'hFF;

      // Short glitch at 115200 is filtered out.
      bus.BaudSelect = 2'b11;
      bc = bitClkFor(2'b11);
      tickWait(20);
      r0 = readyCnt;
      e0 = errCnt;
      d0 = bus.rx_data;
      bus.RxD = 1'b0;
      tickWait(3);
      bus.RxD = 1'b1;
      tickWait(2 * bc);
      check("glitch ready count", readyCnt - r0, 0);
      check("glitch frame_err count", errCnt - e0, 0);
      check("glitch rx_data", bus.rx_data, d0);

      // Back-to-back at 9600 with a single stop bit.
      bus.BaudSelect = 2'b01;
      bc = bitClkFor(2'b01);
      tickWait(20);
      r0 = readyCnt;
      q0 = gotQ.size();
      sendFrame(8'hA3, 1'b1, 0, bc);
      sendFrame(8'h00, 1'b1, 0, bc);
      tickWait(bc);
      check("b2b ready count", readyCnt - r0, 2);
      check("b2b first byte", (gotQ.size() > q0) ? gotQ[q0] : 8'hEE, 8'hA3);
      check("b2b second byte", (gotQ.size() > q0 + 1) ? gotQ[q0+1] : 8'hEE, 8'h00);
      lastGood = 8'h00;

      // Reset during bit 4 of 0xF0, then a clean 0x81.
      bus.BaudSelect = 2'b11;
      bc = bitClkFor(2'b11);
      tickWait(20);
      bus.RxD = 1'b0;
      tickWait(bc);
      for (int i = 0; i < 4; i++) begin
         bus.RxD = 1'b0;
         tickWait(bc);
      end
      bus.RxD = 1'b1;
      tickWait(bc / 2);
      rst = 1'b1;
      tickWait(1);
      check("midreset rx_busy", bus.rx_busy, 0);
      check("midreset rx_data", bus.rx_data, 0);
      check("midreset rx_data_ready", bus.rx_data_ready, 0);
      check("midreset rx_frame_err", bus.rx_frame_err, 0);
      rst = 1'b0;
      tickWait(5 * bc);
      r0 = readyCnt;
      sendFrame(8'h81, 1'b1, 0, bc);
      tickWait(bc);
      check("after reset ready count", readyCnt - r0, 1);
      check("after reset rx_data", bus.rx_data, 8'h81);

      // Rate select changed mid-frame: current byte stays at 115200, next at rate 0.
      r0 = readyCnt;
      fork
         sendFrame(8'h96, 1'b1, 0, bc);
         begin
            tickWait(4 * bc);
            bus.BaudSelect = 2'b00;
         end
      join
      tickWait(bc);
      check("ratechg current ready", readyCnt - r0, 1);
      check("ratechg current rx_data", bus.rx_data, 8'h96);
      bc = bitClkFor(2'b00);
      r0 = readyCnt;
      sendFrame(8'hC5, 1'b1, 0, bc);
      tickWait(bc);
      check("ratechg next ready", readyCnt - r0, 1);
      check("ratechg next rx_data", bus.rx_data, 8'hC5);
      lastGood = 8'hC5;

      // Randomized frames with +/-2% bit-period error against the byte-level model.
      for (int n = 0; n < 4; n++) begin
         rs    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         rb    = 8'($urandom_range(0, 255));
         rStop = ($urandom_range(0, 3) != 0);
         bus.BaudSelect = rs;
         bc = bitClkFor(rs) * (98 + int'($urandom_range(0, 4))) / 100;
         tickWait(20);
         r0 = readyCnt;
         e0 = errCnt;
         sendFrame(rb, rStop, rStop ? 0 : 1, bc);
         tickWait(bc);
         if (rStop) lastGood = rb;
         check($sformatf("rand%0d ready count", n), readyCnt - r0, rStop ? 1 : 0);
         check($sformatf("rand%0d frame_err count", n), errCnt - e0, rStop ? 0 : 1);
         check($sformatf("rand%0d rx_data", n), bus.rx_data, lastGood);
      end

      check("strobe width violations", widthViol, 0);
      check("rx_data changes without strobe", dataViol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

RS-232 receive path for the serial link between the game board and the host PC or opponent board. It converts the asynchronous RxD line into parallel 8N1 bytes, using 16x oversampling, a majority-vote noise filter and mid-bit sampling. The baud rate is selectable at run time from the same four rates as the transmit path. Each received byte produces a one-cycle strobe for the game-protocol decoder.

## Interface
- CLK_FREQ, 24_000_000: clk frequency in Hz.
- BAUD_0 / BAUD_1 / BAUD_2 / BAUD_3, 1200 / 9600 / 38400 / 115200: rates chosen by BaudSelect 00/01/10/11.
- ACC_WIDTH, 16: fractional oversample accumulator width.
- INC_n, derived as round(BAUD_n·16·2^ACC_WIDTH / CLK_FREQ): accumulator increment for rate n (BAUD_3 gives 5033).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- RxD  in  1  asynchronous serial input, idle high.
- BaudSelect  in  2  rate select; latched on start-bit detection.
- rx_data  out  8  last good byte; holds until the next good byte.
- rx_data_ready  out  1  one-cycle pulse when rx_data is updated.
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit.
- rx_busy  out  1  high from start detection until return to IDLE.

## Operation
- Synchronizer: RxD passes through 2 flops, both reset to 1.
- Oversample tick:
  - Accumulator width is ACC_WIDTH+1 bits. Each clk it loads acc[ACC_WIDTH-1:0] + INC_sel.
  - tick = acc[ACC_WIDTH], i.e. a one-cycle pulse.
  - The accumulator free-runs, including in IDLE.
  - INC_sel comes from the latched BaudSelect while rx_busy, otherwise from the live BaudSelect.
- Filter:
  - On each tick, the synchronized bit shifts into a 3-bit register; reset value 3'b111.
  - rxf = majority of the 3 bits.
- Sample counter: 4 bits, counts ticks; bit counter: 3 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on tick with rxf==0, latch BaudSelect, clear sample counter, go to START.
  - START: when the sample counter reaches 7 (mid start bit), check rxf. rxf==0: clear sample counter, go to DATA. rxf==1: false start, go to IDLE with no pulse.
  - DATA: every 16 ticks, shift rxf into bit 7 of the shift register (LSB first). After the 8th bit, go to STOP.
  - STOP: 16 ticks after the last data sample, check rxf.
    - rxf==1: rx_data ← shift register, pulse rx_data_ready, go to IDLE.
    - rxf==0: pulse rx_frame_err, leave rx_data unchanged. Go to BREAK.
  - BREAK: wait for a tick with rxf==1, then go to IDLE. A held-low line produces only one rx_frame_err.
- rx_busy = (state != IDLE).
- rst at any point, including mid-frame:
  - FSM goes to IDLE; counters and shift register clear to 0.
  - rx_data = 8'h00; rx_data_ready = rx_frame_err = rx_busy = 0.
  - A partial frame is discarded.

## Timing
- All outputs are registered.
- rx_data_ready and rx_frame_err are high for exactly one clk.
- rx_data is valid in the same cycle as the rx_data_ready pulse.
- Start-detect latency after the RxD falling edge: 2 clk (sync) plus 2–3 ticks (filter) plus up to 1 tick of phase.
- rx_data_ready occurs about 9.5 bit times after the start edge, within ±1 tick plus 2 clk (mid stop bit).
- Back-to-back frames:
  - The FSM reaches IDLE at mid stop bit, so the next start bit is detected with no gap.
  - Stop bits of 1 bit time or longer must be accepted.
- Error tolerance: accumulated clock error of ±3% over a frame still samples inside each bit.
- A glitch shorter than 2 ticks is rejected by the filter. No state change.

## Test plan
- 115200 baud (BaudSelect=11, bit period 208 clk), send 0x55 → one rx_data_ready pulse, rx_data=0x55, rx_frame_err never asserted.
- 9600 baud (BaudSelect=01, 2500 clk/bit), send 0xA3 then 0x00 back-to-back with a single stop bit → two pulses, rx_data 0xA3 then 0x00.
- At 115200, RxD low for 3 clk only → rx_busy may pulse, but no rx_data_ready, no rx_frame_err, rx_data unchanged.
- At 115200, send 0x3C with stop bit driven low, then hold low for 3 bit times → exactly one rx_frame_err, no rx_data_ready, rx_data keeps its previous value. After RxD returns high and 0x7E is sent, rx_data=0x7E.
- Reset during bit 4 of frame 0xF0 → rx_busy=0 and all outputs at reset values on the next clk. The following 0x81 frame is received correctly.
- Change BaudSelect 11→00 mid-frame → the current byte still decodes at 115200. The next frame at 1200 baud (20000 clk/bit) decodes 0xC5.
